// File: rtl/if_pkg.sv
// Shared definitions for the fetch -> decode instruction queue.
//   XLEN           instruction / address width
//   fq_entry_t     one queued fetch record {inst, addr, branch_taken}
//   is_misaligned  true when an instruction address is not word aligned
package if_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] addr;
        logic            branch_taken;
    } fq_entry_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Control path of the instruction queue: read/write pointers, occupancy,
// full/empty, and push/pop/flush arbitration. Holds no payload.
//   clk, rst   clock (rising edge), synchronous active-high reset
//   fu_valid   fetch presents an instruction
//   du_ready   decode accepts the head
//   flush      drop everything, including a same-cycle input
//   fu_ready   queue can accept (state only, never from du_ready)
//   du_valid   head valid (stored entry, or bypassed input when empty)
//   empty      no stored entries; output mux selects the bypass path
//   wr_en      store the input into the array at wr_ptr
//   rd_ptr     head slot, wr_ptr next free slot, count occupancy
module fq_ptr_ctrl #(
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fu_valid,
    input  logic             du_ready,
    input  logic             flush,
    output logic             fu_ready,
    output logic             du_valid,
    output logic             empty,
    output logic             wr_en,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic push;
    logic pop;
    logic rd_adv;

    assign empty    = (count == '0);
    assign fu_ready = (count != FULL_CNT);

    always_comb begin
        du_valid = 1'b0;
        if (!flush) begin
            if (!empty)
                du_valid = 1'b1;
            else if (BYPASS != 0)
                du_valid = fu_valid;
        end
    end

    assign push   = fu_valid & fu_ready;
    assign pop    = du_valid & du_ready;
    // A pop while empty can only be the bypassed input; it never touches the array.
    assign rd_adv = pop & !empty;
    assign wr_en  = push & !flush & !(pop & empty);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_adv)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_adv);
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode with valid/ready on
// both sides, optional zero-latency bypass when empty, and one-cycle flush.
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   i_fu_valid/inst/addr/branch_taken, o_fu_ready      fetch side
//   o_du_valid/inst/addr/branch_taken/align_error, i_du_ready   decode side
//   i_exec_flush             discard all entries and any same-cycle input
//   o_count                  current occupancy
module inst_fetch_queue #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_fu_valid,
    input  logic [XLEN-1:0]        i_fu_inst,
    input  logic [XLEN-1:0]        i_fu_addr,
    input  logic                   i_fu_branch_taken,
    output logic                   o_fu_ready,
    output logic                   o_du_valid,
    output logic [XLEN-1:0]        o_du_inst,
    output logic [XLEN-1:0]        o_du_addr,
    output logic                   o_du_branch_taken,
    output logic                   o_du_align_error,
    input  logic                   i_du_ready,
    input  logic                   i_exec_flush,
    output logic [$clog2(DEPTH):0] o_count
);

    import if_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("inst_fetch_queue: DEPTH must be a power of two and at least 2");
    end
    if (XLEN != if_pkg::XLEN) begin : g_xlen_chk
        $error("inst_fetch_queue: XLEN must match if_pkg::XLEN");
    end

    logic             empty;
    logic             wr_en;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    fq_entry_t        mem [DEPTH];
    fq_entry_t        sel;

    fq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .BYPASS(BYPASS),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .fu_valid(i_fu_valid),
        .du_ready(i_du_ready),
        .flush   (i_exec_flush),
        .fu_ready(o_fu_ready),
        .du_valid(o_du_valid),
        .empty   (empty),
        .wr_en   (wr_en),
        .rd_ptr  (rd_ptr),
        .wr_ptr  (wr_ptr),
        .count   (o_count)
    );

    // Payload array is not reset; only occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr].inst         <= i_fu_inst;
            mem[wr_ptr].addr         <= i_fu_addr;
            mem[wr_ptr].branch_taken <= i_fu_branch_taken;
        end
    end

    // Head entry when occupied, live input when empty in bypass mode, else zero.
    always_comb begin
        sel = '0;
        if (!empty) begin
            sel = mem[rd_ptr];
        end else if (BYPASS != 0 && i_fu_valid) begin
            sel.inst         = i_fu_inst;
            sel.addr         = i_fu_addr;
            sel.branch_taken = i_fu_branch_taken;
        end
    end

    assign o_du_inst         = sel.inst;
    assign o_du_addr         = sel.addr;
    assign o_du_branch_taken = sel.branch_taken;
    assign o_du_align_error  = is_misaligned(sel.addr);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed and scoreboard bench for inst_fetch_queue. Two instances share the
// same stimulus: d0 is registered-only (BYPASS=0), d1 has the empty bypass.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst, fu_valid, fu_bt, du_ready, flush;
    logic [31:0] fu_inst, fu_addr;

    logic        rdy0, v0, bt0, ae0, rdy1, v1, bt1, ae1;
    logic [31:0] inst0, addr0, inst1, addr1;
    logic [2:0]  cnt0, cnt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(0)) d0 (
        .clk(clk), .rst(rst), .i_fu_valid(fu_valid), .i_fu_inst(fu_inst), .i_fu_addr(fu_addr),
        .i_fu_branch_taken(fu_bt), .o_fu_ready(rdy0), .o_du_valid(v0), .o_du_inst(inst0),
        .o_du_addr(addr0), .o_du_branch_taken(bt0), .o_du_align_error(ae0),
        .i_du_ready(du_ready), .i_exec_flush(flush), .o_count(cnt0));

    inst_fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(1)) d1 (
        .clk(clk), .rst(rst), .i_fu_valid(fu_valid), .i_fu_inst(fu_inst), .i_fu_addr(fu_addr),
        .i_fu_branch_taken(fu_bt), .o_fu_ready(rdy1), .o_du_valid(v1), .o_du_inst(inst1),
        .o_du_addr(addr1), .o_du_branch_taken(bt1), .o_du_align_error(ae1),
        .i_du_ready(du_ready), .i_exec_flush(flush), .o_count(cnt1));

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fu_valid = 1'b0; fu_bt = 1'b0; fu_inst = '0; fu_addr = '0;
        du_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic clear();
        idle();
        flush = 1'b1;
        next();
        flush = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] ins);
        fu_valid = 1'b1; fu_addr = a; fu_inst = ins;
        next();
        fu_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        next(); next();
        n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", v0); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", rdy0); end
        n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", cnt0); end
        n_cmp++; if (addr0 !== 32'h0 || inst0 !== 32'h0) begin n_err++; $display("FAIL reset_payload got %h/%h want 0/0", addr0, inst0); end
        n_cmp++; if (v1 !== 1'b0 || cnt1 !== 3'd0) begin n_err++; $display("FAIL reset_byp got v=%b c=%0d want 0/0", v1, cnt1); end
        rst = 1'b0;
    endtask

    task automatic test_fill_full();
        clear();
        for (int i = 0; i < 4; i++) push(32'(i * 4), 32'hA000 + 32'(i));
        n_cmp++; if (cnt0 !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", cnt0); end
        n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", rdy0); end
        n_cmp++; if (v0 !== 1'b1 || addr0 !== 32'h0) begin n_err++; $display("FAIL full_head got v=%b a=%h want 1/0", v0, addr0); end
        push(32'h10, 32'hA004);
        n_cmp++; if (cnt0 !== 3'd4 || cnt1 !== 3'd4) begin n_err++; $display("FAIL fifth_push got %0d/%0d want 4/4", cnt0, cnt1); end
    endtask

    task automatic test_drain_wrap();
        du_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (v0 !== 1'b1 || addr0 !== 32'(i * 4) || inst0 !== 32'hA000 + 32'(i)) begin
                n_err++; $display("FAIL drain_%0d got v=%b a=%h i=%h want 1/%h/%h", i, v0, addr0, inst0, i * 4, 32'hA000 + 32'(i));
            end
            next();
        end
        n_cmp++; if (cnt0 !== 3'd0 || v0 !== 1'b0) begin n_err++; $display("FAIL drained got c=%0d v=%b want 0/0", cnt0, v0); end
        du_ready = 1'b0;
        push(32'h10, 32'hB010);
        push(32'h14, 32'hB014);
        n_cmp++; if (cnt0 !== 3'd2 || addr0 !== 32'h10) begin n_err++; $display("FAIL wrap_fill got c=%0d a=%h want 2/10", cnt0, addr0); end
        du_ready = 1'b1;
        next();
        n_cmp++; if (addr0 !== 32'h14 || inst0 !== 32'hB014) begin n_err++; $display("FAIL wrap_head got a=%h i=%h want 14/B014", addr0, inst0); end
        next();
        n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL wrap_empty got %0d want 0", cnt0); end
        du_ready = 1'b0;
    endtask

    task automatic test_bypass();
        clear();
        fu_valid = 1'b1; fu_addr = 32'h20; fu_inst = 32'h13; du_ready = 1'b1;
        #1;
        n_cmp++; if (v1 !== 1'b1 || addr1 !== 32'h20 || inst1 !== 32'h13) begin n_err++; $display("FAIL byp_same got v=%b a=%h want 1/20", v1, addr1); end
        n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL nobyp_same got v=%b want 0", v0); end
        next();
        fu_valid = 1'b0;
        n_cmp++; if (cnt1 !== 3'd0) begin n_err++; $display("FAIL byp_count got %0d want 0", cnt1); end
        n_cmp++; if (v0 !== 1'b1 || addr0 !== 32'h20 || cnt0 !== 3'd1) begin n_err++; $display("FAIL nobyp_late got v=%b a=%h c=%0d want 1/20/1", v0, addr0, cnt0); end
        next();
        n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL nobyp_pop got %0d want 0", cnt0); end
        du_ready = 1'b0;
    endtask

    task automatic test_flush();
        clear();
        push(32'h40, 32'h1); push(32'h44, 32'h2); push(32'h48, 32'h3);
        n_cmp++; if (cnt0 !== 3'd3) begin n_err++; $display("FAIL flush_pre got %0d want 3", cnt0); end
        fu_valid = 1'b1; fu_addr = 32'h4C; du_ready = 1'b1; flush = 1'b1;
        next();
        idle();
        n_cmp++; if (cnt0 !== 3'd0 || v0 !== 1'b0) begin n_err++; $display("FAIL flush_post got c=%0d v=%b want 0/0", cnt0, v0); end
        n_cmp++; if (cnt1 !== 3'd0 || v1 !== 1'b0) begin n_err++; $display("FAIL flush_post_byp got c=%0d v=%b want 0/0", cnt1, v1); end
        push(32'h50, 32'h5);
        n_cmp++; if (addr0 !== 32'h50 || cnt0 !== 3'd1) begin n_err++; $display("FAIL flush_lost got a=%h c=%0d want 50/1", addr0, cnt0); end
        clear();
        fu_valid = 1'b1; fu_addr = 32'h60; du_ready = 1'b1; flush = 1'b1;
        #1;
        n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL flush_byp_valid got %b want 0", v1); end
        next();
        idle();
        n_cmp++; if (cnt1 !== 3'd0) begin n_err++; $display("FAIL flush_byp_count got %0d want 0", cnt1); end
    endtask

    task automatic test_align();
        clear();
        fu_valid = 1'b1; fu_addr = 32'h22; fu_inst = 32'h7; fu_bt = 1'b1;
        #1;
        n_cmp++; if (ae1 !== 1'b1 || bt1 !== 1'b1) begin n_err++; $display("FAIL align_byp got ae=%b bt=%b want 1/1", ae1, bt1); end
        next();
        fu_valid = 1'b0; fu_bt = 1'b0;
        n_cmp++; if (ae0 !== 1'b1 || bt0 !== 1'b1 || addr0 !== 32'h22) begin n_err++; $display("FAIL align_head got ae=%b bt=%b a=%h want 1/1/22", ae0, bt0, addr0); end
        push(32'h24, 32'h8);
        du_ready = 1'b1;
        next();
        n_cmp++; if (ae0 !== 1'b0 || bt0 !== 1'b0 || addr0 !== 32'h24) begin n_err++; $display("FAIL align_ok got ae=%b bt=%b a=%h want 0/0/24", ae0, bt0, addr0); end
        du_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        clear();
        push(32'h70, 32'h1); push(32'h74, 32'h2);
        rst = 1'b1;
        next();
        rst = 1'b0;
        n_cmp++; if (cnt0 !== 3'd0 || v0 !== 1'b0 || rdy0 !== 1'b1) begin n_err++; $display("FAIL rst_mid got c=%0d v=%b r=%b want 0/0/1", cnt0, v0, rdy0); end
    endtask

    task automatic test_random();
        logic [64:0] q0[$];
        logic [64:0] q1[$];
        logic [64:0] exp_e, in_e;
        logic        ev0, ev1;
        clear();
        for (int c = 0; c < 10000; c++) begin
            fu_valid = ($urandom_range(0, 3) != 0);
            du_ready = ($urandom_range(0, 1) != 0);
            fu_inst  = $urandom;
            fu_addr  = 32'(c) << 2;
            fu_bt    = $urandom_range(0, 1) != 0;
            #1;
            in_e = {fu_inst, fu_addr, fu_bt};
            ev0 = (q0.size() != 0);
            ev1 = (q1.size() != 0) || fu_valid;
            n_cmp++;
            if (v0 !== ev0 || rdy0 !== (q0.size() < 4) || cnt0 !== 3'(q0.size())) begin
                n_err++; $display("FAIL rnd_state0 cyc %0d got v=%b r=%b c=%0d want %b/%b/%0d", c, v0, rdy0, cnt0, ev0, q0.size() < 4, q0.size());
            end
            n_cmp++;
            if (v1 !== ev1 || rdy1 !== (q1.size() < 4) || cnt1 !== 3'(q1.size())) begin
                n_err++; $display("FAIL rnd_state1 cyc %0d got v=%b r=%b c=%0d want %b/%b/%0d", c, v1, rdy1, cnt1, ev1, q1.size() < 4, q1.size());
            end
            if (fu_valid && q0.size() < 4) q0.push_back(in_e);
            if (fu_valid && q1.size() < 4) q1.push_back(in_e);
            if (ev0 && du_ready && q0.size() != 0) begin
                exp_e = q0.pop_front();
                n_cmp++;
                if ({inst0, addr0, bt0} !== exp_e) begin n_err++; $display("FAIL rnd_data0 cyc %0d got %h want %h", c, {inst0, addr0, bt0}, exp_e); end
            end
            if (ev1 && du_ready && q1.size() != 0) begin
                exp_e = q1.pop_front();
                n_cmp++;
                if ({inst1, addr1, bt1} !== exp_e) begin n_err++; $display("FAIL rnd_data1 cyc %0d got %h want %h", c, {inst1, addr1, bt1}, exp_e); end
            end
            @(posedge clk);
            #1;
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        test_reset();
        test_fill_full();
        test_drain_wrap();
        test_bypass();
        test_flush();
        test_align();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
